// File: rtl/fir_bram_logger.sv
// ---------------------------------------------------------------------------
// fir_bram_logger
//   Capture stage behind the FIR filter. Once armed by i_run, each sample
//   strobed by i_valid is written in order into a block-RAM buffer. Logging
//   stops when the buffer holds DEPTH samples. The stored samples can then be
//   read back at random addresses by host logic.
//
// Ports
//   i_clock     system clock, all logic on the rising edge
//   i_reset     synchronous, active-low reset
//   i_run       1-cycle pulse: clear the count and start logging
//   i_valid     sample strobe
//   i_data      signed filtered sample, stored bit-exact
//   i_rd_req    read request, accepted only while the buffer is full (DONE)
//   i_rd_addr   read address
//   o_rd_data   read data, updated together with o_rd_valid and held otherwise
//   o_rd_valid  1-cycle pulse, two edges after an accepted i_rd_req
//   o_busy      1 while logging (LOG)
//   o_full      1 while the buffer is full (DONE)
//   o_count     samples written since the last i_run (0..DEPTH)
//   o_state     FSM state for debug/checkers (0 IDLE, 1 LOG, 2 DONE)
//
// Handshake: i_valid has no back-pressure. A sample is taken on every rising
// edge where i_valid=1 in LOG. A read is taken on every rising edge where
// i_rd_req=1 in DONE. Its result is presented on o_rd_data/o_rd_valid for
// exactly one cycle, two edges later.
// ---------------------------------------------------------------------------
module fir_bram_logger #(
    parameter int WW_DATA = 8,
    parameter int NB_ADDR = 10
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_run,
    input  logic               i_valid,
    input  logic [WW_DATA-1:0] i_data,
    input  logic               i_rd_req,
    input  logic [NB_ADDR-1:0] i_rd_addr,
    output logic [WW_DATA-1:0] o_rd_data,
    output logic               o_rd_valid,
    output logic               o_busy,
    output logic               o_full,
    output logic [NB_ADDR:0]   o_count,
    output logic [1:0]         o_state
);

    localparam int DEPTH = 2 ** NB_ADDR;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOG  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [NB_ADDR-1:0] PTR_ONE = 1;
    localparam logic [NB_ADDR:0]   CNT_ONE = 1;

    logic [1:0]         state;
    logic [NB_ADDR-1:0] wr_ptr;
    logic [NB_ADDR:0]   count;

    logic [WW_DATA-1:0] mem [DEPTH];
    logic [WW_DATA-1:0] rd_q;
    logic               rd_pend;

    logic wr_en;
    logic rd_en;
    logic wr_last;

    // Reset is folded into both enables so that it also blocks RAM accesses.
    assign wr_en   = i_reset && (state == ST_LOG) && i_valid;
    assign rd_en   = i_reset && (state == ST_DONE) && i_rd_req;
    assign wr_last = &wr_ptr;

    // Control FSM: write pointer, sample count and state
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state  <= ST_IDLE;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_run) begin
                        state  <= ST_LOG;
                        wr_ptr <= '0;
                        count  <= '0;
                    end
                end
                ST_LOG: begin
                    // i_run is ignored here: logging continues uninterrupted
                    if (i_valid) begin
                        count <= count + CNT_ONE;
                        if (wr_last) begin
                            // Pointer holds at the top address instead of wrapping
                            state <= ST_DONE;
                        end else begin
                            wr_ptr <= wr_ptr + PTR_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (i_run) begin
                        state  <= ST_LOG;
                        wr_ptr <= '0;
                        count  <= '0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    wr_ptr <= '0;
                    count  <= '0;
                end
            endcase
        end
    end

    // Buffer RAM: one write port and one registered read port. It has no
    // reset so that it can map onto block RAM.
    always_ff @(posedge i_clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= i_data;
        end
        if (rd_en) begin
            rd_q <= mem[i_rd_addr];
        end
    end

    // Output stage: the second register of the 2-cycle read latency. A read
    // accepted just before a restart still completes with the old data.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            rd_pend    <= 1'b0;
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            rd_pend    <= rd_en;
            o_rd_valid <= rd_pend;
            if (rd_pend) begin
                o_rd_data <= rd_q;
            end
        end
    end

    assign o_busy  = (state == ST_LOG);
    assign o_full  = (state == ST_DONE);
    assign o_count = count;
    assign o_state = state;

endmodule

// File: tb/tb_fir_bram_logger.sv
module tb_fir_bram_logger;

  localparam int W     = 8;
  localparam int NA    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          valid = 1'b0;
  logic [W-1:0]  data = '0;
  logic          rd_req = 1'b0;
  logic [NA-1:0] rd_addr = '0;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic          busy;
  logic          full;
  logic [NA:0]   count;
  logic [1:0]    state;

  int n_chk = 0;
  int n_fail = 0;

  fir_bram_logger #(.WW_DATA(W), .NB_ADDR(NA)) dut (
    .i_clock   (clk),
    .i_reset   (rst_n),
    .i_run     (run),
    .i_valid   (valid),
    .i_data    (data),
    .i_rd_req  (rd_req),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data),
    .o_rd_valid(rd_valid),
    .o_busy    (busy),
    .o_full    (full),
    .o_count   (count),
    .o_state   (state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // behavioural model: a buffer that is either arming, filling or full,
  // plus a queue of read results with the cycle each one is due
  int           cyc = 0;
  bit           m_logging = 0;
  bit           m_full = 0;
  int           m_count = 0;
  logic [W-1:0] m_mem [DEPTH];
  logic [W-1:0] m_rd_data = '0;
  int           due_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_logging = 0;
      m_full = 0;
      m_count = 0;
      m_rd_data = '0;
      due_q.delete();
      exp_q.delete();
    end else begin
      if (m_full && rd_req) begin
        due_q.push_back(cyc + 1);
        exp_q.push_back(m_mem[rd_addr]);
      end
      if (run && !m_logging) begin
        m_logging = 1;
        m_full = 0;
        m_count = 0;
      end else if (m_logging && valid) begin
        m_mem[m_count] = data;
        m_count++;
        if (m_count == DEPTH) begin
          m_logging = 0;
          m_full = 1;
        end
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    if (cyc > 0) begin
      bit exp_v;
      exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
      if (exp_v) begin
        m_rd_data = exp_q.pop_front();
        void'(due_q.pop_front());
      end
      chk("busy", busy, m_logging);
      chk("full", full, m_full);
      chk("count", count, m_count);
      chk("rd_valid", rd_valid, exp_v);
      chk("rd_data", rd_data, m_rd_data);
      if (rd_valid) got_q.push_back(rd_data);
    end
  end

  // driver: inputs change just after a falling edge, hold over the rising edge
  task automatic drive(input bit r, input bit v, input logic [W-1:0] d,
                       input bit rq, input logic [NA-1:0] a);
    run = r; valid = v; data = d; rd_req = rq; rd_addr = a;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, 0, '0);
  endtask

  task automatic sample(input logic [W-1:0] d);
    drive(0, 1, d, 0, '0);
  endtask

  task automatic read(input logic [NA-1:0] a);
    drive(0, 0, '0, 1, a);
  endtask

  initial begin
    // 1 reset with run/valid toggling
    for (int i = 0; i < 5; i++) drive(i[0], ~i[0], W'(i), 1, '0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_state", state, 0);
    rst_n = 1'b1;
    idle(2);

    // 2 fill, one sample every 3rd cycle
    drive(1, 0, '0, 0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      sample(W'(i));
      if (i < DEPTH - 1) chk("fill_busy", busy, 1);
      idle(2);
    end
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);

    // 3 overflow is ignored
    for (int i = 0; i < 5; i++) sample(8'h7F);
    chk("ovf_count", count, 16);
    got_q.delete();
    for (int i = 0; i < DEPTH; i++) read(NA'(i));
    idle(3);
    chk("ovf_nreads", got_q.size(), 16);
    for (int i = 0; i < DEPTH && i < got_q.size(); i++) chk("ovf_data", got_q[i], i);

    // 4 back-to-back reads 3,4,5
    got_q.delete();
    read(3); read(4); read(5);
    idle(3);
    chk("b2b_nreads", got_q.size(), 3);
    for (int i = 0; i < 3 && i < got_q.size(); i++) chk("b2b_data", got_q[i], 3 + i);

    // 5 run edge cases: valid in the run cycle, reads and run while logging
    got_q.delete();
    drive(1, 1, 8'h80, 0, '0);
    for (int i = 0; i < 6; i++) drive(0, 1, 8'h10 + W'(i), 1, NA'(i));
    chk("log_no_reads", got_q.size(), 0);
    drive(1, 0, '0, 0, '0);
    chk("run_in_log_count", count, 6);
    for (int i = 6; i < DEPTH; i++) sample(8'h10 + W'(i));
    chk("edge_count", count, 16);
    chk("edge_full", full, 1);
    got_q.delete();
    read(0); read(5); read(15);
    idle(3);
    chk("edge_nreads", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("edge_mem0", got_q[0], 8'h10);
      chk("edge_mem5", got_q[1], 8'h15);
      chk("edge_mem15", got_q[2], 8'h1F);
    end

    // 6 reset mid-log, refill with A5, restart from DONE
    drive(1, 0, '0, 0, '0);
    for (int i = 0; i < 7; i++) sample(8'h30 + W'(i));
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    chk("midrst_count", count, 0);
    chk("midrst_busy", busy, 0);
    drive(1, 0, '0, 0, '0);
    for (int i = 0; i < DEPTH; i++) sample(8'hA5);
    chk("a5_count", count, 16);
    got_q.delete();
    for (int i = 0; i < DEPTH; i++) read(NA'(i));
    idle(3);
    chk("a5_nreads", got_q.size(), 16);
    foreach (got_q[i]) chk("a5_data", got_q[i], 8'hA5);

    got_q.delete();
    drive(1, 0, '0, 1, 2);
    read(3);
    idle(3);
    chk("inflight_nreads", got_q.size(), 1);
    if (got_q.size() == 1) chk("inflight_data", got_q[0], 8'hA5);
    for (int i = 0; i < DEPTH; i++) sample(8'h40 + W'(i));
    got_q.delete();
    read(0); read(15);
    idle(3);
    chk("restart_nreads", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("restart_mem0", got_q[0], 8'h40);
      chk("restart_mem15", got_q[1], 8'h4F);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
